// File: rtl/instr_type.sv
// Shared load classification produced by decode_load and consumed by load_unit.
package instr_type;
    typedef enum logic [2:0] {
        lk_lb,
        lk_lh,
        lk_lw,
        lk_lbu,
        lk_lhu,
        lk_invalid
    } load_kind_t;
endpackage

// File: rtl/load_unit.sv
// load_unit: executes one decoded RV32I load at a time.
//   Request side : in_valid/in_ready handshake with kind, byte address, rd.
//   Memory side  : single word read (mem_req_valid/mem_req_ready, mem_addr),
//                  response via mem_resp_valid/mem_resp_data (little-endian).
//   Result side  : out_valid/out_ready handshake with extended data, rd and
//                  error flags (illegal kind, misaligned address, timeout fault).
// States: IDLE -> (REQ -> WAIT ->) DONE -> IDLE. Error paths skip memory.
module load_unit
    import instr_type::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  load_kind_t       in_kind,
    input  logic [31:0]      in_addr,
    input  logic [4:0]       in_rd,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [31:0]      mem_addr,
    input  logic             mem_resp_valid,
    input  logic [31:0]      mem_resp_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [4:0]       out_rd,
    output logic             err_illegal,
    output logic             err_misaligned,
    output logic             err_fault
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    load_kind_t      kind_q, kind_d;
    logic [31:0]     addr_q, addr_d;
    logic [4:0]      rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     data_q, data_d;
    logic            ill_q, ill_d;
    logic            mis_q, mis_d;
    logic            flt_q, flt_d;

    logic            in_misaligned;
    logic [31:0]     shifted;
    logic [31:0]     ext;

    // Natural alignment check on the incoming request; bytes never fault.
    always_comb begin
        in_misaligned = 1'b0;
        case (in_kind)
            lk_lh, lk_lhu: in_misaligned = in_addr[0];
            lk_lw:         in_misaligned = |in_addr[1:0];
            default:       in_misaligned = 1'b0;
        endcase
    end

    // Bring the addressed byte/half down to bit 0, then extend by kind.
    always_comb begin
        shifted = mem_resp_data >> {addr_q[1:0], 3'b000};
        ext     = '0;
        case (kind_q)
            lk_lb:   ext = {{24{shifted[7]}}, shifted[7:0]};
            lk_lbu:  ext = {24'd0, shifted[7:0]};
            lk_lh:   ext = {{16{shifted[15]}}, shifted[15:0]};
            lk_lhu:  ext = {16'd0, shifted[15:0]};
            lk_lw:   ext = shifted;
            default: ext = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        ill_d   = ill_q;
        mis_d   = mis_q;
        flt_d   = flt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    kind_d = in_kind;
                    addr_d = in_addr;
                    rd_d   = in_rd;
                    data_d = '0;
                    if (in_kind == lk_invalid) begin
                        ill_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (in_misaligned) begin
                        mis_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response in the cycle the counter hits the limit still wins.
                if (mem_resp_valid) begin
                    data_d  = ext;
                    state_d = S_DONE;
                end else if (cnt_q == TMO) begin
                    data_d  = '0;
                    flt_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    ill_d   = 1'b0;
                    mis_d   = 1'b0;
                    flt_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            kind_q  <= lk_lb;
            addr_q  <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            ill_q   <= 1'b0;
            mis_q   <= 1'b0;
            flt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ill_q   <= ill_d;
            mis_q   <= mis_d;
            flt_q   <= flt_d;
        end
    end

    assign in_ready       = (state_q == S_IDLE);
    assign mem_req_valid  = (state_q == S_REQ);
    assign mem_addr       = {addr_q[31:2], 2'b00};
    assign out_valid      = (state_q == S_DONE);
    assign out_data       = data_q;
    assign out_rd         = rd_q;
    assign err_illegal    = ill_q;
    assign err_misaligned = mis_q;
    assign err_fault      = flt_q;

endmodule
